// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int BAUD_W = 12;
    localparam int BYTE_W = 8;
    localparam logic [BAUD_W-1:0] DEFAULT_BAUD = 12'd434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        CLR   = 2'd2,
        BUSY  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Rotating priority search starting at ptr.
    always_comb begin
        winner     = {NUM_REQ{1'b0}};
        winner_idx = {IDX_W{1'b0}};
        found_s    = 1'b0;
        cand_s     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found_s && req[cand_s]) begin
                winner[cand_s] = 1'b1;
                winner_idx     = cand_s;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler, baud register owner and receive drain.
// Optional tx_done watchdog with sticky tx_err: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int          NUM_REQ      = 4,
    parameter logic [11:0] DEFAULT_BAUD = uart_sched_pkg::DEFAULT_BAUD,
    parameter logic [15:0] TIMEOUT      = 16'd60000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    input  logic                   cfg_we,
    input  logic [11:0]            cfg_baud,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic [11:0]            baud_goal,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   clr_rx_rdy,
    output logic                   rx_valid,
    output logic [7:0]             rx_byte,
    output logic                   busy,
    output logic                   tx_err
);

    import uart_sched_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e         state_r;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     win_r;
    logic [BAUD_W-1:0]    pend_baud_r;
    logic                 pend_vld_r;
    logic [NUM_REQ-1:0]   win_oh_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic                 any_req_s;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [15:0]          tmo_cnt_r;
`endif

    assign any_req_s = |req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .ptr        (ptr_r),
        .winner     (win_oh_s),
        .winner_idx (win_idx_s)
    );

    // Transmit FSM, baud register and grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            win_r       <= {IDX_W{1'b0}};
            pend_baud_r <= DEFAULT_BAUD;
            pend_vld_r  <= 1'b0;
            baud_goal   <= DEFAULT_BAUD;
            trmt        <= 1'b0;
            gnt         <= {NUM_REQ{1'b0}};
            tx_data     <= 8'h00;
            busy        <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            tmo_cnt_r   <= 16'd0;
            tx_err      <= 1'b0;
`endif
        end else begin
            trmt <= 1'b0;
            gnt  <= {NUM_REQ{1'b0}};
            if (cfg_we) begin
                pend_baud_r <= cfg_baud;
                pend_vld_r  <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    // A fresh write this cycle defers the apply so the newest value lands.
                    if (pend_vld_r && !cfg_we) begin
                        baud_goal  <= pend_baud_r;
                        pend_vld_r <= 1'b0;
                    end else if (pend_vld_r) begin
                        state_r <= IDLE;
                    end else if (any_req_s) begin
                        win_r   <= win_idx_s;
                        tx_data <= req_data[{win_idx_s, 3'b000} +: BYTE_W];
                        trmt    <= 1'b1;
                        gnt     <= win_oh_s;
                        busy    <= 1'b1;
                        state_r <= START;
                    end
                end
                START: begin
                    ptr_r   <= (win_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : win_r + IDX_W'(1);
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    tmo_cnt_r <= 16'd0;
`endif
                    state_r <= CLR;
                end
                CLR: begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    tmo_cnt_r <= tmo_cnt_r + 16'd1;
`endif
                    state_r <= BUSY;
                end
                BUSY: begin
                    if (tx_done) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    end else if (tmo_cnt_r >= TIMEOUT - 16'd1) begin
                        busy    <= 1'b0;
                        tx_err  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
`endif
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifndef UART_TX_SCHED_TIMEOUT_EN
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT;
    assign tx_err           = 1'b0;
`endif

    // Receive drain: one valid/clear pulse per byte, re-armed once the clear has been seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte    <= 8'h00;
            rx_valid   <= 1'b0;
            clr_rx_rdy <= 1'b0;
        end else if (rx_rdy && !clr_rx_rdy) begin
            rx_byte    <= rx_data;
            rx_valid   <= 1'b1;
            clr_rx_rdy <= 1'b1;
        end else begin
            rx_valid   <= 1'b0;
            clr_rx_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed, table-driven bench for uart_tx_sched with a simple UART tx_done model.
module tb_uart_tx_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        cfg_we;
    logic [11:0] cfg_baud;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [11:0] baud_goal;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        busy;
    logic        tx_err;

    int n_cmp = 0;
    int n_err = 0;
    int n_trmt = 0;
    int n_done = 0;
    int done_cnt = 0;
    bit done_en = 1'b1;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [9];
    logic [3:0] cont_gnt  [5];
    logic [7:0] cont_byte [5];

    uart_tx_sched #(
        .NUM_REQ      (4),
        .DEFAULT_BAUD (12'd434),
        .TIMEOUT      (16'd100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .cfg_we     (cfg_we),
        .cfg_baud   (cfg_baud),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .baud_goal  (baud_goal),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .busy       (busy),
        .tx_err     (tx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART transmitter model: trmt clears tx_done, which rises 10 cycles later.
    initial begin
        tx_done = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (trmt) begin
                tx_done  = 1'b0;
                done_cnt = 10;
                n_trmt++;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0 && done_en) begin
                    tx_done = 1'b1;
                    n_done++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(input int lim, output int cnt, output bit ok);
        cnt = 0;
        ok  = 1'b0;
        while (!ok && cnt < lim) begin
            @(negedge clk);
            cnt++;
            if (gnt != 4'b0000) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int lim, output int cnt, output bit ok);
        cnt = 0;
        ok  = 1'b0;
        while (!ok && cnt < lim) begin
            @(negedge clk);
            cnt++;
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_trmt"},    32'(trmt),       32'h0);
        check({tag, "_gnt"},     32'(gnt),        32'h0);
        check({tag, "_tx_data"}, 32'(tx_data),    32'h0);
        check({tag, "_baud"},    32'(baud_goal),  32'd434);
        check({tag, "_clr_rx"},  32'(clr_rx_rdy), 32'h0);
        check({tag, "_rx_vld"},  32'(rx_valid),   32'h0);
        check({tag, "_rx_byte"}, 32'(rx_byte),    32'h0);
        check({tag, "_busy"},    32'(busy),       32'h0);
        check({tag, "_tx_err"},  32'(tx_err),     32'h0);
    endtask

    initial begin
        int cnt;
        bit ok;
        int tr0;
        int d0;
        int n_v;
        int n_c;

        rst = 1'b1; req = 4'b0000; req_data = 32'h0; cfg_we = 1'b0; cfg_baud = 12'd0;
        rx_rdy = 1'b0; rx_data = 8'h00;
        tr0 = 0; d0 = 0;

        // pointer starts at 3 after the A5 byte; expectations follow the rotation
        vecs[0] = '{4'b1111, 32'h4433_2211, 4'b1000, 8'h44};
        vecs[1] = '{4'b1111, 32'h4433_2211, 4'b0001, 8'h11};
        vecs[2] = '{4'b0101, 32'h8877_6655, 4'b0100, 8'h77};
        vecs[3] = '{4'b0011, 32'hDEAD_BEEF, 4'b0001, 8'hEF};
        vecs[4] = '{4'b0011, 32'hDEAD_BEEF, 4'b0010, 8'hBE};
        vecs[5] = '{4'b1001, 32'h0102_0304, 4'b1000, 8'h01};
        vecs[6] = '{4'b1010, 32'hF0E1_D2C3, 4'b0010, 8'hD2};
        vecs[7] = '{4'b0001, 32'h0000_005A, 4'b0001, 8'h5A};
        vecs[8] = '{4'b1000, 32'hFF00_0000, 4'b1000, 8'hFF};
        cont_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cont_byte = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        // single byte from requester 2
        @(posedge clk); #1;
        req = 4'b0100; req_data = 32'h00A5_0000;
        wait_gnt(20, cnt, ok);
        check("a5_gnt_seen", 32'(ok), 32'h1);
        check("a5_latency", 32'(cnt), 32'd2);
        check("a5_gnt", 32'(gnt), 32'h4);
        check("a5_trmt", 32'(trmt), 32'h1);
        check("a5_tx_data", 32'(tx_data), 32'hA5);
        check("a5_busy", 32'(busy), 32'h1);
        @(posedge clk); #1 req = 4'b0000;
        cnt = 0;
        while (!tx_done && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("a5_busy_at_done", 32'(busy), 32'h1);
        check("a5_tx_data_stable", 32'(tx_data), 32'hA5);
        @(negedge clk);
        check("a5_busy_fall", 32'(busy), 32'h0);

        // arbitration table
        for (int r = 0; r < 9; r++) begin
            @(posedge clk); #1;
            req = vecs[r].req; req_data = vecs[r].data;
            wait_gnt(20, cnt, ok);
            check($sformatf("vec%0d_gnt", r), 32'(gnt), 32'(vecs[r].exp_gnt));
            check($sformatf("vec%0d_trmt", r), 32'(trmt), 32'h1);
            check($sformatf("vec%0d_tx_data", r), 32'(tx_data), 32'(vecs[r].exp_byte));
            @(posedge clk); #1 req = 4'b0000;
            wait_idle(40, cnt, ok);
            check($sformatf("vec%0d_idle", r), 32'(ok), 32'h1);
        end

        // baud write while busy is held until IDLE
        @(posedge clk); #1;
        req = 4'b0001; req_data = 32'h0000_00C7;
        wait_gnt(20, cnt, ok);
        check("baud_b1_gnt", 32'(gnt), 32'h1);
        check("baud_b1_goal", 32'(baud_goal), 32'd434);
        @(posedge clk); #1 req = 4'b0000; cfg_we = 1'b1; cfg_baud = 12'd27;
        @(posedge clk); #1 cfg_we = 1'b0;
        @(negedge clk);
        check("baud_busy_hold", 32'(baud_goal), 32'd434);
        wait_idle(40, cnt, ok);
        check("baud_idle_ok", 32'(ok), 32'h1);
        check("baud_idle_entry", 32'(baud_goal), 32'd434);
        @(negedge clk);
        check("baud_applied", 32'(baud_goal), 32'd27);
        @(posedge clk); #1;
        req = 4'b0010; req_data = 32'h0000_5E00;
        wait_gnt(20, cnt, ok);
        check("baud_b2_latency", 32'(cnt), 32'd2);
        check("baud_b2_gnt", 32'(gnt), 32'h2);
        check("baud_b2_goal", 32'(baud_goal), 32'd27);
        @(posedge clk); #1 req = 4'b0000; cfg_we = 1'b1; cfg_baud = 12'd54;
        @(posedge clk); #1 cfg_we = 1'b0; req = 4'b0100; req_data = 32'h0069_0000;
        wait_idle(40, cnt, ok);
        check("defer_idle_ok", 32'(ok), 32'h1);
        @(negedge clk);
        check("defer_baud", 32'(baud_goal), 32'd54);
        check("defer_no_trmt", 32'(trmt), 32'h0);
        @(negedge clk);
        check("defer_trmt", 32'(trmt), 32'h1);
        check("defer_gnt", 32'(gnt), 32'h4);
        check("defer_tx_data", 32'(tx_data), 32'h69);
        @(posedge clk); #1 req = 4'b0000;
        wait_idle(40, cnt, ok);

        // receive drain: rx_rdy held until the clear is seen
        @(posedge clk); #1 rx_data = 8'h3C; rx_rdy = 1'b1;
        n_v = 0; n_c = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rx_valid) n_v++;
            if (clr_rx_rdy) begin
                n_c++;
                @(posedge clk); #1 rx_rdy = 1'b0;
            end
        end
        check("rx_valid_pulses", 32'(n_v), 32'd1);
        check("rx_clr_pulses", 32'(n_c), 32'd1);
        check("rx_byte", 32'(rx_byte), 32'h3C);

        // reset in the middle of a transfer
        @(posedge clk); #1;
        req = 4'b0001; req_data = 32'h0000_0099;
        wait_gnt(20, cnt, ok);
        @(posedge clk); #1 req = 4'b0000;
        repeat (3) @(negedge clk);
        check("mid_busy_before_rst", 32'(busy), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("mid_rst");
        @(posedge clk); #1 rst = 1'b0;

        // all requesters held: fresh pointer gives 0,1,2,3,0
        @(posedge clk); #1;
        req = 4'b1111; req_data = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(40, cnt, ok);
            check($sformatf("cont%0d_gnt", k), 32'(gnt), 32'(cont_gnt[k]));
            check($sformatf("cont%0d_tx_data", k), 32'(tx_data), 32'(cont_byte[k]));
            if (k == 0) begin
                tr0 = n_trmt;
                d0  = n_done;
            end else begin
                check($sformatf("cont%0d_gap", k), 32'(cnt), 32'd12);
            end
        end
        @(posedge clk); #1 req = 4'b0000;
        wait_idle(40, cnt, ok);
        check("cont_trmt_count", 32'(n_trmt - tr0), 32'd4);
        check("cont_done_count", 32'(n_done - d0), 32'd5);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        done_en = 1'b0;
        @(posedge clk); #1;
        req = 4'b0001; req_data = 32'h0000_0077;
        wait_gnt(20, cnt, ok);
        @(posedge clk); #1 req = 4'b0000;
        wait_idle(300, cnt, ok);
        check("tmo_idle_ok", 32'(ok), 32'h1);
        check("tmo_cycles", 32'(cnt), 32'd100);
        check("tmo_err", 32'(tx_err), 32'h1);
        done_en = 1'b1;
        @(posedge clk); #1;
        req = 4'b0010; req_data = 32'h0000_8800;
        wait_gnt(20, cnt, ok);
        check("tmo_next_gnt", 32'(gnt), 32'h2);
        @(posedge clk); #1 req = 4'b0000;
        wait_idle(40, cnt, ok);
        check("tmo_next_idle", 32'(ok), 32'h1);
        check("tmo_err_sticky", 32'(tx_err), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("tmo_err_cleared", 32'(tx_err), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
`else
        check("tx_err_tied", 32'(tx_err), 32'h0);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
